// File: rtl/rom_player_pkg.sv
// Shared types and constants for the ROM pattern player.
//   state_t : playback FSM states
//   dir_t   : address walk direction
//   MODE_*  : playback mode encodings presented on the mode input
package rom_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      LOAD  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [1:0] MODE_LOOP     = 2'd0;
   localparam logic [1:0] MODE_ONESHOT  = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;
   localparam logic [1:0] MODE_REVLOOP  = 2'd3;

endpackage

// File: rtl/rom_player_prescaler.sv
// Hold-time prescaler for the ROM pattern player.
// Counts 0..divisor while enabled and flags the terminal count.
//   Clk0, AsyncReset0 : clock, async active-high reset
//   clear             : synchronous return to 0 (priority over enable)
//   enable            : advance the count this cycle
//   divisor           : terminal count value
//   tick              : count == divisor
module rom_player_prescaler #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 Clk0,
   input  logic                 AsyncReset0,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 tick
);

   localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic [DIV_WIDTH-1:0] r_count;

   assign tick = (r_count == divisor);

   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= tick ? '0 : r_count + ONE;
      end
   end

endmodule

// File: rtl/rom_pattern_player.sv
// ROM pattern player: walks an address window of an external synchronous-read
// ROM and presents each word on a registered output at a programmable rate.
//   Clk0, AsyncReset0      : clock, async active-high reset
//   start, stop            : playback control (start honoured only in IDLE)
//   mode, first_addr,
//   last_addr, divisor     : configuration, captured on an accepted start
//   rom_addr / rom_data    : ROM read port (data valid one cycle after addr)
//   pattern_out/_strobe    : current word and its update pulse
//   busy, done, cfg_err    : status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// PRIME | rom_addr just changed, waiting out the ROM read latency
// LOAD  | rom_data valid: capture into pattern_out, strobe, clear prescaler
// HOLD  | hold pattern for divisor+1 cycles, then step the address
module rom_pattern_player
   import rom_player_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  Clk0,
   input  logic                  AsyncReset0,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   input  logic [DIV_WIDTH-1:0]  divisor,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] pattern_out,
   output logic                  pattern_strobe,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                r_state;
   dir_t                  r_dir;
   logic [1:0]            r_mode;
   logic [ADDR_WIDTH-1:0] r_first;
   logic [ADDR_WIDTH-1:0] r_last;
   logic [DIV_WIDTH-1:0]  r_divisor;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_pattern;
   logic                  r_strobe;
   logic                  r_done;
   logic                  r_cfg_err;

   state_t                w_state_next;
   dir_t                  w_dir_next;
   dir_t                  w_step_dir;
   logic [ADDR_WIDTH-1:0] w_addr_next;
   logic [ADDR_WIDTH-1:0] w_step_addr;
   logic                  w_latch;
   logic                  w_load;
   logic                  w_done;
   logic                  w_cfg_err;
   logic                  w_clear;
   logic                  w_tick;

   rom_player_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .Clk0        (Clk0),
      .AsyncReset0 (AsyncReset0),
      .clear       (w_clear),
      .enable      (r_state == HOLD),
      .divisor     (r_divisor),
      .tick        (w_tick)
   );

   // Address that follows r_addr when the hold time expires.
   always_comb begin
      w_step_addr = r_addr;
      w_step_dir  = r_dir;
      case (r_mode)
         MODE_LOOP:    w_step_addr = (r_addr == r_last)  ? r_first : r_addr + A_ONE;
         MODE_ONESHOT: w_step_addr = r_addr + A_ONE;
         MODE_REVLOOP: w_step_addr = (r_addr == r_first) ? r_last  : r_addr - A_ONE;
         default: begin
            // Single-word window: nothing to bounce between, stay put.
            if (r_first != r_last) begin
               if (r_dir == DIR_UP) begin
                  if (r_addr == r_last) begin
                     w_step_dir  = DIR_DOWN;
                     w_step_addr = r_addr - A_ONE;
                  end else begin
                     w_step_addr = r_addr + A_ONE;
                  end
               end else begin
                  if (r_addr == r_first) begin
                     w_step_dir  = DIR_UP;
                     w_step_addr = r_addr + A_ONE;
                  end else begin
                     w_step_addr = r_addr - A_ONE;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      w_dir_next   = r_dir;
      w_latch      = 1'b0;
      w_load       = 1'b0;
      w_done       = 1'b0;
      w_cfg_err    = 1'b0;
      w_clear      = 1'b0;
      if (r_state != IDLE && stop) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !stop) begin
                  if (first_addr > last_addr) begin
                     w_cfg_err = 1'b1;
                  end else begin
                     w_latch      = 1'b1;
                     w_state_next = PRIME;
                     if (mode == MODE_REVLOOP) begin
                        w_addr_next = last_addr;
                        w_dir_next  = DIR_DOWN;
                     end else begin
                        w_addr_next = first_addr;
                        w_dir_next  = DIR_UP;
                     end
                  end
               end
            end
            PRIME: w_state_next = LOAD;
            LOAD: begin
               w_load       = 1'b1;
               w_clear      = 1'b1;
               w_state_next = HOLD;
            end
            default: begin
               if (w_tick) begin
                  if (r_mode == MODE_ONESHOT && r_addr == r_last) begin
                     w_done       = 1'b1;
                     w_state_next = IDLE;
                  end else begin
                     w_addr_next  = w_step_addr;
                     w_dir_next   = w_step_dir;
                     w_state_next = PRIME;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         r_state   <= IDLE;
         r_dir     <= DIR_UP;
         r_mode    <= MODE_LOOP;
         r_first   <= '0;
         r_last    <= '0;
         r_divisor <= '0;
         r_addr    <= '0;
         r_pattern <= '0;
         r_strobe  <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_dir     <= w_dir_next;
         r_addr    <= w_addr_next;
         r_strobe  <= w_load;
         r_done    <= w_done;
         r_cfg_err <= w_cfg_err;
         if (w_load) begin
            r_pattern <= rom_data;
         end
         if (w_latch) begin
            r_mode    <= mode;
            r_first   <= first_addr;
            r_last    <= last_addr;
            r_divisor <= divisor;
         end
      end
   end

   assign rom_addr       = r_addr;
   assign pattern_out    = r_pattern;
   assign pattern_strobe = r_strobe;
   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_rom_pattern_player.sv
// Directed testbench for rom_pattern_player with a behavioural ROM (data = address).
module tb_rom_pattern_player;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] first_addr = '0;
   logic [11:0] last_addr = '0;
   logic [15:0] divisor = '0;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data = '0;
   logic [7:0]  pattern_out;
   logic        pattern_strobe;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int n_pass = 0;
   int n_total = 0;

   rom_pattern_player #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DIV_WIDTH(16)) dut (
      .Clk0           (clk),
      .AsyncReset0    (rst),
      .start          (start),
      .stop           (stop),
      .mode           (mode),
      .first_addr     (first_addr),
      .last_addr      (last_addr),
      .divisor        (divisor),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .pattern_out    (pattern_out),
      .pattern_strobe (pattern_strobe),
      .busy           (busy),
      .done           (done),
      .cfg_err        (cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_addr[7:0];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until a strobe is seen; n = cycles waited, -1 on timeout.
   task automatic wait_strobe(input int max_cyc, output logic [7:0] d, output int n);
      d = 8'hxx;
      n = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         step();
         if (pattern_strobe === 1'b1) begin
            d = pattern_out;
            n = i;
            return;
         end
      end
   endtask

   task automatic start_run(input logic [1:0] m, input logic [11:0] f, input logic [11:0] l,
                            input logic [15:0] dv);
      mode = m; first_addr = f; last_addr = l; divisor = dv;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic stop_run();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      n_total++;
      if ({rom_addr, pattern_out, pattern_strobe, busy, done, cfg_err} !== 24'd0) begin
         $display("FAIL reset_outputs: got addr=%0d pat=%0d stb=%b busy=%b done=%b err=%b, want all 0",
                  rom_addr, pattern_out, pattern_strobe, busy, done, cfg_err);
      end else n_pass++;
   endtask

   task automatic test_loop();
      logic [7:0] exp_seq [5] = '{8'd4, 8'd5, 8'd6, 8'd4, 8'd5};
      logic [7:0] d;
      int n;
      start_run(2'd0, 12'd4, 12'd6, 16'd1);
      n_total++;
      if (busy !== 1'b1 || rom_addr !== 12'd4) begin
         $display("FAIL loop_start: busy=%b addr=%0d, want busy=1 addr=4", busy, rom_addr);
      end else n_pass++;
      for (int k = 0; k < 5; k++) begin
         wait_strobe(20, d, n);
         n_total++;
         if (d !== exp_seq[k]) begin
            $display("FAIL loop_pattern[%0d]: got %0d, want %0d", k, d, exp_seq[k]);
         end else n_pass++;
         n_total++;
         if (n !== ((k == 0) ? 2 : 4)) begin
            $display("FAIL loop_interval[%0d]: got %0d, want %0d", k, n, (k == 0) ? 2 : 4);
         end else n_pass++;
      end
      stop_run();
   endtask

   task automatic test_oneshot();
      logic [7:0] d;
      int n;
      start_run(2'd1, 12'd10, 12'd12, 16'd0);
      for (int k = 0; k < 3; k++) begin
         wait_strobe(20, d, n);
         n_total++;
         if (d !== 8'(10 + k) || n !== ((k == 0) ? 2 : 3)) begin
            $display("FAIL oneshot_pattern[%0d]: got %0d after %0d, want %0d after %0d",
                     k, d, n, 10 + k, (k == 0) ? 2 : 3);
         end else n_pass++;
      end
      // One HOLD cycle (divisor 0) after the last strobe, then done.
      step();
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || pattern_out !== 8'd12) begin
         $display("FAIL oneshot_done: done=%b busy=%b pat=%0d, want 1 0 12", done, busy, pattern_out);
      end else n_pass++;
      step();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || pattern_out !== 8'd12 || pattern_strobe !== 1'b0) begin
         $display("FAIL oneshot_after: done=%b busy=%b pat=%0d stb=%b, want 0 0 12 0",
                  done, busy, pattern_out, pattern_strobe);
      end else n_pass++;
   endtask

   task automatic test_pingpong();
      logic [7:0] exp_seq [7] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
      logic [7:0] d;
      int n;
      start_run(2'd2, 12'd0, 12'd2, 16'd0);
      for (int k = 0; k < 7; k++) begin
         wait_strobe(20, d, n);
         n_total++;
         if (d !== exp_seq[k]) begin
            $display("FAIL pingpong_pattern[%0d]: got %0d, want %0d", k, d, exp_seq[k]);
         end else n_pass++;
      end
      stop_run();
      start_run(2'd2, 12'd7, 12'd7, 16'd0);
      for (int k = 0; k < 3; k++) begin
         wait_strobe(20, d, n);
         n_total++;
         if (d !== 8'd7 || busy !== 1'b1 || rom_addr !== 12'd7) begin
            $display("FAIL pingpong_single[%0d]: pat=%0d busy=%b addr=%0d, want 7 1 7",
                     k, d, busy, rom_addr);
         end else n_pass++;
      end
      stop_run();
   endtask

   task automatic test_revloop();
      logic [7:0] exp_seq [4] = '{8'd5, 8'd4, 8'd3, 8'd5};
      logic [7:0] d;
      int n;
      start_run(2'd3, 12'd3, 12'd5, 16'd0);
      n_total++;
      if (rom_addr !== 12'd5) begin
         $display("FAIL revloop_start_addr: got %0d, want 5", rom_addr);
      end else n_pass++;
      for (int k = 0; k < 4; k++) begin
         wait_strobe(20, d, n);
         n_total++;
         if (d !== exp_seq[k]) begin
            $display("FAIL revloop_pattern[%0d]: got %0d, want %0d", k, d, exp_seq[k]);
         end else n_pass++;
      end
      stop_run();
      start_run(2'd0, 12'd9, 12'd8, 16'd0);
      n_total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL cfg_err_pulse: err=%b busy=%b, want 1 0", cfg_err, busy);
      end else n_pass++;
      step();
      n_total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL cfg_err_clear: err=%b busy=%b, want 0 0", cfg_err, busy);
      end else n_pass++;
   endtask

   task automatic test_stop();
      logic [7:0] d;
      int n;
      start_run(2'd0, 12'd4, 12'd6, 16'd3);
      wait_strobe(20, d, n);
      wait_strobe(20, d, n);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_total++;
      if (busy !== 1'b0 || pattern_out !== 8'd5 || done !== 1'b0 || rom_addr !== 12'd5) begin
         $display("FAIL stop_hold: busy=%b pat=%0d done=%b addr=%0d, want 0 5 0 5",
                  busy, pattern_out, done, rom_addr);
      end else n_pass++;
      start = 1'b1;
      stop = 1'b1;
      first_addr = 12'd1;
      last_addr = 12'd2;
      step();
      start = 1'b0;
      stop = 1'b0;
      n_total++;
      if (busy !== 1'b0 || rom_addr !== 12'd5 || cfg_err !== 1'b0) begin
         $display("FAIL start_with_stop: busy=%b addr=%0d err=%b, want 0 5 0", busy, rom_addr, cfg_err);
      end else n_pass++;
   endtask

   task automatic test_start_while_busy();
      logic [7:0] d;
      int n;
      start_run(2'd0, 12'd4, 12'd6, 16'd2);
      wait_strobe(20, d, n);
      mode = 2'd3; first_addr = 12'd0; last_addr = 12'd9; divisor = 16'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_strobe(20, d, n);
      n_total++;
      if (d !== 8'd5 || n !== 4) begin
         $display("FAIL busy_start_1: got %0d after %0d, want 5 after 4", d, n);
      end else n_pass++;
      wait_strobe(20, d, n);
      n_total++;
      if (d !== 8'd6 || n !== 5) begin
         $display("FAIL busy_start_2: got %0d after %0d, want 6 after 5", d, n);
      end else n_pass++;
      stop_run();
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      int n;
      start_run(2'd0, 12'd4, 12'd6, 16'd1);
      wait_strobe(20, d, n);
      wait_strobe(20, d, n);
      #3;
      rst = 1'b1;
      #1;
      n_total++;
      if ({rom_addr, pattern_out, pattern_strobe, busy, done, cfg_err} !== 24'd0) begin
         $display("FAIL async_reset: addr=%0d pat=%0d stb=%b busy=%b done=%b err=%b, want all 0",
                  rom_addr, pattern_out, pattern_strobe, busy, done, cfg_err);
      end else n_pass++;
      step();
      #2;
      rst = 1'b0;
      step();
      start_run(2'd0, 12'd4, 12'd6, 16'd1);
      n_total++;
      if (busy !== 1'b1 || rom_addr !== 12'd4) begin
         $display("FAIL restart: busy=%b addr=%0d, want 1 4", busy, rom_addr);
      end else n_pass++;
      wait_strobe(20, d, n);
      n_total++;
      if (d !== 8'd4 || n !== 2) begin
         $display("FAIL restart_pattern: got %0d after %0d, want 4 after 2", d, n);
      end else n_pass++;
      wait_strobe(20, d, n);
      n_total++;
      if (d !== 8'd5 || n !== 4) begin
         $display("FAIL restart_next: got %0d after %0d, want 5 after 4", d, n);
      end else n_pass++;
      stop_run();
   endtask

   initial begin
      rst = 1'b1;
      #1;
      test_reset();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      step();
      test_reset();
      test_loop();
      test_oneshot();
      test_pingpong();
      test_revloop();
      test_stop();
      test_start_while_busy();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
